line_fill_wb_engine: RTL and testbench

- Line-transfer engine directly downstream of the cache controller FSM.
- Takes one request per miss: optional dirty-victim write-back, then optional refill.
- Moves whole 64-byte lines word by word over a simple req/ack main-memory port.
- Streams refill words into the cache data array and reports completion with a single done pulse, which the controller uses as its memory-ready condition.

---
 rtl/line_fill_wb_engine_pkg.sv | 26 ++
 rtl/line_fill_wb_engine_if.sv | 49 ++++
 rtl/line_fill_wb_engine_counter.sv | 26 ++
 rtl/line_fill_wb_engine.sv | 131 +++++++++++++
 tb/tb_line_fill_wb_engine.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/line_fill_wb_engine_pkg.sv
// Shared cache definitions: line-engine state encoding, line geometry and
// address-field positions common to the cache controller and the line engine.
package cache_pkg;

  localparam int ADDR_W     = 32;
  localparam int WORD_W     = 32;
  localparam int OFFSET_W   = 6;
  localparam int WORD_IDX_W = OFFSET_W - 2;
  localparam int WORDS      = 1 << WORD_IDX_W;

  // Address split: [TAG_MSB:TAG_LSB] tag, [SET_MSB:SET_LSB] set, [OFFSET_MSB:0] offset
  localparam int SET_W      = 7;
  localparam int OFFSET_MSB = OFFSET_W - 1;
  localparam int SET_LSB    = OFFSET_W;
  localparam int SET_MSB    = SET_LSB + SET_W - 1;
  localparam int TAG_LSB    = SET_MSB + 1;
  localparam int TAG_MSB    = ADDR_W - 1;

  typedef enum logic [1:0] {
    LE_IDLE = 2'd0,
    LE_WB   = 2'd1,
    LE_FILL = 2'd2,
    LE_DONE = 2'd3
  } line_state_t;

endpackage

// File: rtl/line_fill_wb_engine_if.sv
// Bundle between the cache controller / data array / main memory and the
// line-transfer engine. The engine takes the slave view.
interface line_fill_wb_engine_if
  import cache_pkg::*;
#(
  parameter int ADDRESS_WIDTH = ADDR_W,
  parameter int DATA_WIDTH    = WORD_W,
  parameter int OFFSET_WIDTH  = OFFSET_W
);
  localparam int IDX_W = OFFSET_WIDTH - 2;

  logic                     req_valid;
  logic                     req_ready;
  logic                     req_wb;
  logic                     req_fill;
  logic [ADDRESS_WIDTH-1:0] victim_addr;
  logic [ADDRESS_WIDTH-1:0] fill_addr;

  logic [IDX_W-1:0]         wb_word_idx;
  logic [DATA_WIDTH-1:0]    wb_word;
  logic                     fill_we;
  logic [IDX_W-1:0]         fill_word_idx;
  logic [DATA_WIDTH-1:0]    fill_data;

  logic                     done;
  logic                     busy;

  logic                     mem_req;
  logic                     mem_we;
  logic [ADDRESS_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0]    mem_wdata;
  logic [DATA_WIDTH-1:0]    mem_rdata;
  logic                     mem_ack;

  modport slave (
    input  req_valid, req_wb, req_fill, victim_addr, fill_addr,
    input  wb_word, mem_rdata, mem_ack,
    output req_ready, wb_word_idx, fill_we, fill_word_idx, fill_data,
    output done, busy, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_wb, req_fill, victim_addr, fill_addr,
    output wb_word, mem_rdata, mem_ack,
    input  req_ready, wb_word_idx, fill_we, fill_word_idx, fill_data,
    input  done, busy, mem_req, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/line_fill_wb_engine_counter.sv
// Word index within a line; shared by the write-back and refill phases.
module line_word_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         last
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Natural wrap of the W-bit counter returns it to 0 after the last word.
  assign last = &cnt;

endmodule

// File: rtl/line_fill_wb_engine.sv
// Line-transfer engine: optional dirty-victim write-back then optional refill,
// one word per accepted memory transfer, single done pulse on completion.
module line_fill_wb_engine
  import cache_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int OFFSET_WIDTH  = 6
) (
  input  logic                 clk,
  input  logic                 reset_n,
  line_fill_wb_engine_if.slave bus
);

  localparam int IDX_W  = OFFSET_WIDTH - 2;
  localparam int LINE_W = ADDRESS_WIDTH - OFFSET_WIDTH;

  line_state_t             state, state_nxt;
  logic [LINE_W-1:0]       victim_line;
  logic [LINE_W-1:0]       fill_line;
  logic                    fill_pend;
  logic [IDX_W-1:0]        cnt;
  logic                    cnt_last;
  logic                    accept;
  logic                    xfer;
  logic                    in_xfer_state;
  logic                    fill_we_q;
  logic [IDX_W-1:0]        fill_idx_q;
  logic [DATA_WIDTH-1:0]   fill_data_q;

  assign accept        = bus.req_valid && (state == LE_IDLE);
  assign in_xfer_state = (state == LE_WB) || (state == LE_FILL);
  assign xfer          = in_xfer_state && bus.mem_ack;

  line_word_counter #(.W(IDX_W)) u_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (state == LE_IDLE),
    .inc     (xfer),
    .cnt     (cnt),
    .last    (cnt_last)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= LE_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LE_IDLE: begin
        if (bus.req_valid) begin
          if (bus.req_wb)        state_nxt = LE_WB;
          else if (bus.req_fill) state_nxt = LE_FILL;
          else                   state_nxt = LE_DONE;
        end
      end
      LE_WB: begin
        if (xfer && cnt_last) state_nxt = fill_pend ? LE_FILL : LE_DONE;
      end
      LE_FILL: begin
        if (xfer && cnt_last) state_nxt = LE_DONE;
      end
      LE_DONE: state_nxt = LE_IDLE;
      default: state_nxt = LE_IDLE;
    endcase
  end

  // Memory-side and cache-read-side outputs are decoded straight from state so
  // an asynchronous reset drops mem_req in the same cycle.
  always_comb begin
    bus.req_ready   = 1'b0;
    bus.busy        = 1'b1;
    bus.done        = 1'b0;
    bus.mem_req     = 1'b0;
    bus.mem_we      = 1'b0;
    bus.mem_addr    = '0;
    bus.mem_wdata   = '0;
    bus.wb_word_idx = '0;
    case (state)
      LE_IDLE: begin
        bus.req_ready = 1'b1;
        bus.busy      = 1'b0;
      end
      LE_WB: begin
        bus.mem_req     = 1'b1;
        bus.mem_we      = 1'b1;
        bus.mem_addr    = {victim_line, cnt, 2'b00};
        bus.mem_wdata   = bus.wb_word;
        bus.wb_word_idx = cnt;
      end
      LE_FILL: begin
        bus.mem_req  = 1'b1;
        bus.mem_addr = {fill_line, cnt, 2'b00};
      end
      LE_DONE: bus.done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      victim_line <= '0;
      fill_line   <= '0;
      fill_pend   <= 1'b0;
      fill_we_q   <= 1'b0;
      fill_idx_q  <= '0;
      fill_data_q <= '0;
    end else begin
      if (accept) begin
        victim_line <= bus.victim_addr[ADDRESS_WIDTH-1:OFFSET_WIDTH];
        fill_line   <= bus.fill_addr[ADDRESS_WIDTH-1:OFFSET_WIDTH];
        fill_pend   <= bus.req_fill;
      end
      fill_we_q <= (state == LE_FILL) && xfer;
      if ((state == LE_FILL) && xfer) begin
        fill_idx_q  <= cnt;
        fill_data_q <= bus.mem_rdata;
      end
    end
  end

  assign bus.fill_we       = fill_we_q;
  assign bus.fill_word_idx = fill_idx_q;
  assign bus.fill_data     = fill_data_q;

endmodule

// File: tb/tb_line_fill_wb_engine.sv
// Directed bench for line_fill_wb_engine with a small memory responder
// (tied or 3-wait-cycle ack) and a pattern-generating victim-word source.
module tb_line_fill_wb_engine;

  logic clk = 1'b0;
  logic reset_n;
  logic ack_tied;
  int   wait_cnt;
  int   errors = 0;
  int   checks = 0;

  line_fill_wb_engine_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .OFFSET_WIDTH(6)) bus();

  line_fill_wb_engine #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .OFFSET_WIDTH(6)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] wbw(input int i);
    logic [31:0] v;
    v = i;
    return 32'hB000_0000 | (v * 32'h11);
  endfunction

  function automatic logic [31:0] rd(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  assign bus.wb_word   = wbw(int'(bus.wb_word_idx));
  assign bus.mem_rdata = rd(bus.mem_addr);
  assign bus.mem_ack   = ack_tied | (wait_cnt == 3);

  always @(posedge clk) begin
    if (!bus.mem_req || bus.mem_ack) wait_cnt <= 0;
    else                             wait_cnt <= wait_cnt + 1;
  end

  task automatic issue(input logic wb, input logic fill, input logic [31:0] va, input logic [31:0] fa);
    bus.req_valid   = 1'b1;
    bus.req_wb      = wb;
    bus.req_fill    = fill;
    bus.victim_addr = va;
    bus.fill_addr   = fa;
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_wb = 1'b0; bus.req_fill = 1'b0;
    bus.victim_addr = '0; bus.fill_addr = '0;
    ack_tied = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", bus.req_ready); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got %b want 0", bus.mem_req); end
    checks++; if (bus.done !== 1'b0 || bus.fill_we !== 1'b0) begin errors++; $display("FAIL reset_strobes done=%b fill_we=%b want 0/0", bus.done, bus.fill_we); end
    checks++; if (bus.mem_addr !== 32'h0 || bus.fill_data !== 32'h0 || bus.fill_word_idx !== 4'h0) begin
      errors++; $display("FAIL reset_data addr=%h fdata=%h fidx=%h want 0", bus.mem_addr, bus.fill_data, bus.fill_word_idx); end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fill_only;
    ack_tied = 1'b1;
    issue(1'b0, 1'b1, 32'h0, 32'h0000_1234);
    for (int i = 0; i < 16; i++) begin
      checks++; if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0) begin errors++; $display("FAIL fill_req[%0d] req=%b we=%b want 1/0", i, bus.mem_req, bus.mem_we); end
      checks++; if (bus.mem_addr !== 32'h1200 + 32'(4 * i)) begin errors++; $display("FAIL fill_addr[%0d] got %h want %h", i, bus.mem_addr, 32'h1200 + 32'(4 * i)); end
      checks++; if (bus.fill_we !== (i > 0) || bus.done !== 1'b0) begin errors++; $display("FAIL fill_we[%0d] we=%b done=%b want %b/0", i, bus.fill_we, bus.done, i > 0); end
      if (i > 0) begin
        checks++; if (bus.fill_word_idx !== 4'(i - 1) || bus.fill_data !== rd(32'h1200 + 32'(4 * (i - 1)))) begin
          errors++; $display("FAIL fill_data[%0d] idx=%h data=%h want %h/%h", i, bus.fill_word_idx, bus.fill_data, 4'(i - 1), rd(32'h1200 + 32'(4 * (i - 1)))); end
      end
      @(negedge clk);
    end
    checks++; if (bus.done !== 1'b1 || bus.fill_we !== 1'b1 || bus.mem_req !== 1'b0) begin
      errors++; $display("FAIL fill_done done=%b we=%b req=%b want 1/1/0", bus.done, bus.fill_we, bus.mem_req); end
    checks++; if (bus.fill_word_idx !== 4'hF || bus.fill_data !== rd(32'h123C)) begin
      errors++; $display("FAIL fill_last idx=%h data=%h want f/%h", bus.fill_word_idx, bus.fill_data, rd(32'h123C)); end
    @(negedge clk);
    checks++; if (bus.done !== 1'b0 || bus.req_ready !== 1'b1 || bus.fill_we !== 1'b0) begin
      errors++; $display("FAIL fill_idle done=%b ready=%b we=%b want 0/1/0", bus.done, bus.req_ready, bus.fill_we); end
  endtask

  task automatic test_wb_fill;
    ack_tied = 1'b0;
    issue(1'b1, 1'b1, 32'h0000_4000, 32'h0000_8040);
    for (int w = 0; w < 16; w++) begin
      for (int c = 0; c < 4; c++) begin
        checks++; if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1 || bus.done !== 1'b0) begin
          errors++; $display("FAIL wb_ctl[%0d.%0d] req=%b we=%b done=%b want 1/1/0", w, c, bus.mem_req, bus.mem_we, bus.done); end
        checks++; if (bus.mem_addr !== 32'h4000 + 32'(4 * w) || bus.wb_word_idx !== 4'(w) || bus.mem_wdata !== wbw(w)) begin
          errors++; $display("FAIL wb_word[%0d.%0d] addr=%h idx=%h wdata=%h want %h/%h/%h", w, c, bus.mem_addr, bus.wb_word_idx, bus.mem_wdata, 32'h4000 + 32'(4 * w), 4'(w), wbw(w)); end
        @(negedge clk);
      end
    end
    for (int w = 0; w < 16; w++) begin
      for (int c = 0; c < 4; c++) begin
        checks++; if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0 || bus.done !== 1'b0 || bus.mem_addr !== 32'h8040 + 32'(4 * w)) begin
          errors++; $display("FAIL wbf_rd[%0d.%0d] req=%b we=%b done=%b addr=%h want 1/0/0/%h", w, c, bus.mem_req, bus.mem_we, bus.done, bus.mem_addr, 32'h8040 + 32'(4 * w)); end
        checks++; if (bus.fill_we !== (c == 0 && w > 0)) begin errors++; $display("FAIL wbf_we[%0d.%0d] got %b want %b", w, c, bus.fill_we, (c == 0 && w > 0)); end
        if (c == 0 && w > 0) begin
          checks++; if (bus.fill_word_idx !== 4'(w - 1) || bus.fill_data !== rd(32'h8040 + 32'(4 * (w - 1)))) begin
            errors++; $display("FAIL wbf_data[%0d] idx=%h data=%h want %h/%h", w, bus.fill_word_idx, bus.fill_data, 4'(w - 1), rd(32'h8040 + 32'(4 * (w - 1)))); end
        end
        @(negedge clk);
      end
    end
    checks++; if (bus.done !== 1'b1 || bus.fill_we !== 1'b1 || bus.fill_word_idx !== 4'hF || bus.fill_data !== rd(32'h807C)) begin
      errors++; $display("FAIL wbf_done done=%b we=%b idx=%h data=%h want 1/1/f/%h", bus.done, bus.fill_we, bus.fill_word_idx, bus.fill_data, rd(32'h807C)); end
    @(negedge clk);
    checks++; if (bus.done !== 1'b0 || bus.req_ready !== 1'b1) begin errors++; $display("FAIL wbf_idle done=%b ready=%b want 0/1", bus.done, bus.req_ready); end
  endtask

  task automatic test_empty;
    ack_tied = 1'b1;
    issue(1'b0, 1'b0, 32'h0000_4000, 32'h0000_8000);
    checks++; if (bus.done !== 1'b1 || bus.mem_req !== 1'b0 || bus.busy !== 1'b1) begin
      errors++; $display("FAIL empty_done done=%b req=%b busy=%b want 1/0/1", bus.done, bus.mem_req, bus.busy); end
    @(negedge clk);
    checks++; if (bus.done !== 1'b0 || bus.mem_req !== 1'b0 || bus.req_ready !== 1'b1) begin
      errors++; $display("FAIL empty_idle done=%b req=%b ready=%b want 0/0/1", bus.done, bus.mem_req, bus.req_ready); end
  endtask

  task automatic test_reset_mid_wb;
    int n;
    ack_tied = 1'b1;
    issue(1'b1, 1'b0, 32'h0000_4000, 32'h0);
    repeat (5) @(negedge clk);
    checks++; if (bus.wb_word_idx !== 4'h5 || bus.mem_addr !== 32'h4014) begin
      errors++; $display("FAIL rst_pre idx=%h addr=%h want 5/00004014", bus.wb_word_idx, bus.mem_addr); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (bus.mem_req !== 1'b0 || bus.mem_we !== 1'b0 || bus.busy !== 1'b0 || bus.req_ready !== 1'b1) begin
      errors++; $display("FAIL rst_ctl req=%b we=%b busy=%b ready=%b want 0/0/0/1", bus.mem_req, bus.mem_we, bus.busy, bus.req_ready); end
    checks++; if (bus.mem_addr !== 32'h0 || bus.wb_word_idx !== 4'h0 || bus.done !== 1'b0 || bus.mem_wdata !== 32'h0) begin
      errors++; $display("FAIL rst_out addr=%h idx=%h done=%b wdata=%h want 0", bus.mem_addr, bus.wb_word_idx, bus.done, bus.mem_wdata); end
    @(negedge clk);
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL rst_nodone got %b want 0", bus.done); end
    reset_n = 1'b1;
    @(negedge clk);
    issue(1'b1, 1'b0, 32'h0000_4000, 32'h0);
    checks++; if (bus.mem_addr !== 32'h4000 || bus.wb_word_idx !== 4'h0 || bus.mem_wdata !== wbw(0)) begin
      errors++; $display("FAIL rst_restart addr=%h idx=%h wdata=%h want 00004000/0/%h", bus.mem_addr, bus.wb_word_idx, bus.mem_wdata, wbw(0)); end
    n = 0;
    while (!bus.done && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++; if (n !== 16) begin errors++; $display("FAIL rst_redo_len cycles=%0d want 16", n); end
    @(negedge clk);
  endtask

  task automatic test_busy_ignore;
    int dones;
    ack_tied = 1'b1;
    dones = 0;
    issue(1'b0, 1'b1, 32'h0, 32'h0000_2000);
    for (int i = 0; i < 16; i++) begin
      checks++; if (bus.mem_addr !== 32'h2000 + 32'(4 * i)) begin errors++; $display("FAIL ign_addr[%0d] got %h want %h", i, bus.mem_addr, 32'h2000 + 32'(4 * i)); end
      if (bus.done) dones++;
      if (i == 3) begin bus.req_valid = 1'b1; bus.req_wb = 1'b1; bus.fill_addr = 32'h0000_9000; end
      if (i == 5) bus.req_valid = 1'b0;
      @(negedge clk);
    end
    for (int k = 0; k < 3; k++) begin
      if (bus.done) dones++;
      @(negedge clk);
    end
    checks++; if (dones !== 1) begin errors++; $display("FAIL ign_dones got %0d want 1", dones); end
    checks++; if (bus.busy !== 1'b0 || bus.mem_req !== 1'b0) begin errors++; $display("FAIL ign_idle busy=%b req=%b want 0/0", bus.busy, bus.mem_req); end
    bus.req_wb = 1'b0;
  endtask

  task automatic test_wrap;
    ack_tied = 1'b1;
    issue(1'b0, 1'b1, 32'h0, 32'hFFFF_FFC4);
    for (int i = 0; i < 16; i++) begin
      checks++; if (bus.mem_addr !== 32'hFFFF_FFC0 + 32'(4 * i)) begin errors++; $display("FAIL wrap_addr[%0d] got %h want %h", i, bus.mem_addr, 32'hFFFF_FFC0 + 32'(4 * i)); end
      @(negedge clk);
    end
    checks++; if (bus.done !== 1'b1 || bus.fill_word_idx !== 4'hF || bus.fill_data !== rd(32'hFFFF_FFFC)) begin
      errors++; $display("FAIL wrap_done done=%b idx=%h data=%h want 1/f/%h", bus.done, bus.fill_word_idx, bus.fill_data, rd(32'hFFFF_FFFC)); end
    checks++; if (dut.u_cnt.cnt !== 4'h0) begin errors++; $display("FAIL wrap_cnt got %h want 0", dut.u_cnt.cnt); end
    @(negedge clk);
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL wrap_idle ready=%b want 1", bus.req_ready); end
  endtask

  initial begin
    test_reset();
    test_fill_only();
    test_wb_fill();
    test_empty();
    test_reset_mid_wb();
    test_busy_ignore();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
